lane_to_fifo_bridge: RTL and testbench

Receive-side counterpart of the lane transmit bridge. It takes a byte stream from a lane receiver during bursts framed by `lane_active`, marks the last byte of each burst, and writes 11-bit words into a downstream RX FIFO. It also enforces a minimum packet-to-packet gap and closes packets damaged by overflow or lane errors with an error terminator word. It sits between the per-lane receiver and the RX packet FIFO feeding the packet parser.

---
 rtl/lane_rx_pkg.sv | 30 +++
 rtl/lane_to_fifo_bridge.sv | 130 +++++++++++++
 tb/tb_lane_to_fifo_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lane_rx_pkg.sv
// Shared types and FIFO word layout for the lane receive bridge.
// Word layout: {err, mode_lp, eop, data[7:0]}.
package lane_rx_pkg;

  localparam int unsigned WORD_W      = 11;
  localparam int unsigned RX_ERR_BIT  = 10;
  localparam int unsigned RX_MODE_BIT = 9;
  localparam int unsigned RX_EOP_BIT  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop,
    StTerm
  } rx_state_t;

  function automatic logic [WORD_W-1:0] rx_word(input logic       err,
                                                input logic       mode_lp,
                                                input logic       eop,
                                                input logic [7:0] data);
    logic [WORD_W-1:0] w;
    w              = '0;
    w[RX_ERR_BIT]  = err;
    w[RX_MODE_BIT] = mode_lp;
    w[RX_EOP_BIT]  = eop;
    w[7:0]         = data;
    return w;
  endfunction

endpackage

// File: rtl/lane_to_fifo_bridge.sv
// Lane receiver to RX FIFO bridge: one-byte hold to tag end-of-packet, packet gap
// enforcement, and error termination of damaged packets.
module lane_to_fifo_bridge #(
  parameter int unsigned WORD_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lane_active,
  input  logic              lane_valid,
  input  logic [7:0]        lane_data,
  input  logic              lane_mode_lp,
  input  logic              lane_err,
  input  logic              fifo_full,
  output logic              fifo_write,
  output logic [WORD_W-1:0] fifo_data,
  input  logic [15:0]       p2p_timeout,
  output logic              rx_busy,
  output logic              err_pulse,
  output logic [15:0]       err_count
);
  import lane_rx_pkg::*;

  rx_state_t   state_q, state_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        hold_valid_q, hold_valid_d;
  logic        mode_q, mode_d;
  logic        wrote_any_q, wrote_any_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] err_count_q;

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    mode_d       = mode_q;
    wrote_any_d  = wrote_any_q;
    gap_cnt_d    = (gap_cnt_q != 16'd0) ? gap_cnt_q - 16'd1 : 16'd0;
    fifo_write   = 1'b0;
    fifo_data    = '0;
    err_pulse    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lane_active) begin
          hold_valid_d = 1'b0;
          wrote_any_d  = 1'b0;
          if (gap_cnt_q == 16'd0) begin
            state_d = StRecv;
          end else begin
            state_d   = StDrop;
            err_pulse = 1'b1;
          end
        end
      end
      StRecv: begin
        if (!lane_active) begin
          gap_cnt_d = p2p_timeout;
          if (!hold_valid_q) begin
            state_d = StIdle;
          end else if (!fifo_full) begin
            fifo_write   = 1'b1;
            fifo_data    = rx_word(1'b0, mode_q, 1'b1, hold_data_q);
            hold_valid_d = 1'b0;
            state_d      = StIdle;
          end
        end else if (lane_err) begin
          state_d      = StDrop;
          hold_valid_d = 1'b0;
          err_pulse    = 1'b1;
        end else if (lane_valid) begin
          if (!hold_valid_q) begin
            // Hold empty inside RECV only happens for the first byte of a packet.
            hold_data_d  = lane_data;
            hold_valid_d = 1'b1;
            mode_d       = lane_mode_lp;
          end else if (!fifo_full) begin
            fifo_write  = 1'b1;
            fifo_data   = rx_word(1'b0, mode_q, 1'b0, hold_data_q);
            hold_data_d = lane_data;
            wrote_any_d = 1'b1;
          end else begin
            state_d      = StDrop;
            hold_valid_d = 1'b0;
            err_pulse    = 1'b1;
          end
        end
      end
      StDrop: begin
        if (!lane_active) begin
          gap_cnt_d = p2p_timeout;
          state_d   = wrote_any_q ? StTerm : StIdle;
        end
      end
      StTerm: begin
        if (!fifo_full) begin
          fifo_write = 1'b1;
          fifo_data  = rx_word(1'b1, mode_q, 1'b1, 8'h00);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_data_q  <= 8'h00;
      hold_valid_q <= 1'b0;
      mode_q       <= 1'b0;
      wrote_any_q  <= 1'b0;
      gap_cnt_q    <= 16'd0;
      err_count_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      mode_q       <= mode_d;
      wrote_any_q  <= wrote_any_d;
      gap_cnt_q    <= gap_cnt_d;
      if (err_pulse && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign rx_busy   = (state_q != StIdle);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lane_to_fifo_bridge.sv
// Self-checking bench: table-driven packets, directed overflow/stall/reset sequences,
// and randomized packets scored against a packet-level reference model.
module tb_lane_to_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lane_active = 1'b0;
  logic        lane_valid = 1'b0;
  logic [7:0]  lane_data = 8'h00;
  logic        lane_mode_lp = 1'b0;
  logic        lane_err = 1'b0;
  logic        fifo_full = 1'b0;
  logic [15:0] p2p_timeout = 16'd10;
  logic        fifo_write;
  logic [10:0] fifo_data;
  logic        rx_busy;
  logic        err_pulse;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];
  int exp_errs = 0;
  int seen_pulses = 0;
  int last_t = 0;
  bit gap_zero = 1'b1;
  logic [7:0] pkt_b [8];
  bit pkt_stall [8];

  typedef struct {
    logic            mode;
    int              n;
    logic [3:0][7:0] b;
    int              err_idx;
    int              gap;
    int              exp_n;
    logic [3:0][10:0] exp_w;
    int              exp_err;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  lane_to_fifo_bridge #(.WORD_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lane_active (lane_active),
    .lane_valid  (lane_valid),
    .lane_data   (lane_data),
    .lane_mode_lp(lane_mode_lp),
    .lane_err    (lane_err),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_data   (fifo_data),
    .p2p_timeout (p2p_timeout),
    .rx_busy     (rx_busy),
    .err_pulse   (err_pulse),
    .err_count   (err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard and pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_write) begin
        if (fifo_full) check("write_while_full", 32'(fifo_write), 32'(1'b0));
        if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_data), 32'h7FF_FFFF);
        else check("fifo_word", 32'(fifo_data), 32'(exp_q.pop_front()));
      end
      if (err_pulse) seen_pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    lane_active = 1'b0;
    lane_valid  = 1'b0;
    lane_err    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic mark_end();
    lane_active = 1'b0;
    lane_valid  = 1'b0;
    lane_err    = 1'b0;
    last_t      = int'(p2p_timeout);
    gap_zero    = 1'b0;
  endtask

  task automatic post_checks(input string tag);
    idle(3);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_errs));
    check({tag, "_err_pulses"}, 32'(seen_pulses), 32'(exp_errs));
  endtask

  // gap = idle cycles between previous packet end and this packet's lane_active rise (>= 3).
  task automatic do_packet(input logic mode, input int n, input int err_idx, input int gap,
                           input string tag);
    idle(gap - 3);
    lane_active = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      lane_valid   = 1'b1;
      lane_data    = pkt_b[i];
      lane_mode_lp = (i == 0) ? mode : ~mode;
      lane_err     = (i == err_idx);
      tick();
      lane_err = 1'b0;
      if (pkt_stall[i]) begin
        lane_valid = 1'b0;
        tick();
      end
    end
    mark_end();
    post_checks(tag);
  endtask

  // Packet-level reference: gap rule from idle length, then whole-packet outcome.
  task automatic model_push(input logic mode, input int n, input int err_idx, input int gap);
    bit viol;
    viol = !gap_zero && (last_t != 0) && (gap <= last_t);
    if (viol) begin
      exp_errs++;
    end else if (err_idx < n) begin
      exp_errs++;
      for (int j = 0; j < err_idx - 1; j++) exp_q.push_back({1'b0, mode, 1'b0, pkt_b[j]});
      if (err_idx >= 2) exp_q.push_back({1'b1, mode, 1'b1, 8'h00});
    end else begin
      for (int j = 0; j < n; j++) exp_q.push_back({1'b0, mode, (j == n - 1), pkt_b[j]});
    end
  endtask

  function automatic vec_t mk(input logic mode, input int n, input logic [31:0] b,
                              input int err_idx, input int gap, input int exp_n,
                              input logic [43:0] exp_w, input int exp_err);
    vec_t v;
    v.mode = mode; v.n = n; v.b = b; v.err_idx = err_idx; v.gap = gap;
    v.exp_n = exp_n; v.exp_w = exp_w; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_fifo_write"}, 32'(fifo_write), 32'd0);
    check({tag, "_fifo_data"}, 32'(fifo_data), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    // p2p_timeout = 10 for the table; gap 10 is a violation, gap 11 is the first legal one.
    vecs[0] = mk(1'b0, 3, 32'h0033_2211, 99, 12, 3, {11'h000, 11'h133, 11'h022, 11'h011}, 0);
    vecs[1] = mk(1'b1, 1, 32'h0000_00A5, 99, 12, 1, {33'h0, 11'h3A5}, 0);
    vecs[2] = mk(1'b0, 2, 32'h0000_5544, 99, 5, 0, 44'h0, 1);
    vecs[3] = mk(1'b0, 2, 32'h0000_7766, 99, 12, 2, {22'h0, 11'h177, 11'h066}, 0);
    vecs[4] = mk(1'b0, 1, 32'h0000_0088, 0, 12, 0, 44'h0, 1);
    vecs[5] = mk(1'b0, 0, 32'h0, 99, 12, 0, 44'h0, 0);
    vecs[6] = mk(1'b1, 4, 32'h0403_0201, 3, 12, 3, {11'h000, 11'h700, 11'h202, 11'h201}, 1);
    vecs[7] = mk(1'b0, 2, 32'h0000_BC9A, 99, 11, 2, {22'h0, 11'h1BC, 11'h09A}, 0);
    vecs[8] = mk(1'b0, 1, 32'h0000_0012, 99, 10, 0, 44'h0, 1);

    rst_n = 1'b0;
    tick();
    tick();
    reset_checks("reset");
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) begin
        pkt_b[i]     = (i < 4) ? vecs[k].b[i] : 8'h00;
        pkt_stall[i] = (k == 3) && (i == 0);
      end
      for (int j = 0; j < vecs[k].exp_n; j++) exp_q.push_back(vecs[k].exp_w[j]);
      exp_errs += vecs[k].exp_err;
      do_packet(vecs[k].mode, vecs[k].n, vecs[k].err_idx, vecs[k].gap,
                $sformatf("vec%0d", k));
    end

    // Overflow on the second write: one good word, then terminator once full releases.
    idle(10);
    lane_active = 1'b1; tick();
    lane_valid = 1'b1; lane_mode_lp = 1'b0; lane_data = 8'hD1; tick();
    lane_mode_lp = 1'b1; lane_data = 8'hD2; exp_q.push_back(11'h0D1); tick();
    fifo_full = 1'b1; lane_data = 8'hD3;
    @(negedge clk);
    check("ovf_pulse", 32'(err_pulse), 32'd1);
    check("ovf_count_before", 32'(err_count), 32'(exp_errs));
    exp_errs++;
    tick();
    lane_data = 8'hD4;
    @(negedge clk);
    check("ovf_count_after", 32'(err_count), 32'(exp_errs));
    tick();
    mark_end();
    tick();
    @(negedge clk);
    check("term_wait_busy", 32'(rx_busy), 32'd1);
    check("term_wait_nowrite", 32'(fifo_write), 32'd0);
    tick();
    exp_q.push_back(11'h500);
    fifo_full = 1'b0;
    post_checks("ovf");

    // Burst ends while FIFO full: last byte waits in RECV.
    idle(10);
    lane_active = 1'b1; tick();
    lane_valid = 1'b1; lane_mode_lp = 1'b0; lane_data = 8'hE1; tick();
    lane_data = 8'hE2; exp_q.push_back(11'h0E1); tick();
    mark_end();
    fifo_full = 1'b1;
    tick();
    @(negedge clk);
    check("eop_stall_nowrite", 32'(fifo_write), 32'd0);
    check("eop_stall_busy", 32'(rx_busy), 32'd1);
    tick();
    exp_q.push_back(11'h1E2);
    fifo_full = 1'b0;
    post_checks("eop_stall");

    // Reset mid-packet abandons the held byte; next packet is clean.
    idle(10);
    lane_active = 1'b1; tick();
    lane_valid = 1'b1; lane_mode_lp = 1'b0; lane_data = 8'h31; tick();
    lane_data = 8'h32; exp_q.push_back(11'h031); tick();
    rst_n = 1'b0;
    lane_active = 1'b0;
    lane_valid = 1'b0;
    tick();
    reset_checks("midreset");
    tick();
    exp_q.delete();
    exp_errs = 0;
    seen_pulses = 0;
    gap_zero = 1'b1;
    rst_n = 1'b1;
    pkt_b[0] = 8'h41; pkt_b[1] = 8'h42; pkt_stall[0] = 1'b0; pkt_stall[1] = 1'b0;
    model_push(1'b1, 2, 99, 3);
    do_packet(1'b1, 2, 99, 3, "after_reset");

    // Randomized packets, FIFO never full, against the packet-level model.
    p2p_timeout = 16'($urandom_range(3, 8));
    for (int k = 0; k < 60; k++) begin
      int n, err_idx, gap;
      logic mode;
      n = $urandom_range(0, 6);
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        pkt_b[i] = 8'($urandom);
        pkt_stall[i] = ($urandom_range(0, 3) == 0);
      end
      err_idx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : 99;
      gap = (k == 0) ? 20 : $urandom_range(3, int'(p2p_timeout) + 4);
      model_push(mode, n, err_idx, gap);
      do_packet(mode, n, err_idx, gap, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
